// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage.
package instruction_fetch_pkg;

  // Default instruction-memory word-address width.
  localparam int unsigned IMEM_ADDR_WIDTH = 14;

  // Encoding presented to decode whenever no live instruction is held.
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] data_out,
  output logic [31:0] pc_out
);

  // Capture on load; clear wins so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      data_out <= NOP;
      pc_out   <= 32'h0;
    end else if (clear) begin
      valid    <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
      pc_out   <= pc_in;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues ROM reads from pc, aligns returning data with its pc and
// presents it to decode, absorbing a decode stall with a one-entry skid.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  stall,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_valid,
  output logic                  keep_pc
);

  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_issue;
  logic        hold;
  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic [31:0] inst_d;
  logic [31:0] inst_pc_d;
  logic        inst_valid_d;

  assign imem_addr = pc[ADDR_WIDTH-1:0];

  // Output is frozen only when decode stalls on a live instruction.
  assign hold      = stall & inst_valid;
  // Once the skid is full nothing more may be issued, so no return can find it occupied.
  assign keep_pc   = skid_valid | hold;
  assign req_issue = ~keep_pc;

  // A return that arrives while the output is frozen is parked in the skid.
  assign skid_load  = ~flush & hold & req_valid;
  assign skid_clear = flush | ~hold;

  // Track the read launched this cycle so its data can be claimed next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_pc    <= 32'h0;
    end else begin
      req_valid <= req_issue & ~flush;
      req_pc    <= pc;
    end
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (imem_data),
    .pc_in    (req_pc),
    .valid    (skid_valid),
    .data_out (skid_data),
    .pc_out   (skid_pc)
  );

  // Select the next presented instruction: flush, hold, skid first, then the return.
  always_comb begin
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    if (flush) begin
      inst_d       = NOP;
      inst_pc_d    = 32'h0;
      inst_valid_d = 1'b0;
    end else if (!hold) begin
      if (skid_valid) begin
        inst_d       = skid_data;
        inst_pc_d    = skid_pc;
        inst_valid_d = 1'b1;
      end else if (req_valid) begin
        inst_d       = imem_data;
        inst_pc_d    = req_pc;
        inst_valid_d = 1'b1;
      end else begin
        inst_d       = NOP;
        inst_pc_d    = 32'h0;
        inst_valid_d = 1'b0;
      end
    end
  end

  // Output register presented to decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst       <= NOP;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
    end
  end

endmodule
